// File: rtl/vga_scan_pkg.sv
// VGA 640x480@60 timing constants and RGB565 colour expansion
// shared by the SRAM frame scan-out block.
package vga_scan_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = 800;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = 525;

  function automatic logic [23:0] rgb565_unpack(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel phase, h/v raster counters, raw syncs and frame strobes.
// Counters advance on the second cycle of each 2-cycle pixel slot.
module vga_timing_gen #(
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int H_SW    = 96,
  parameter int H_BACK  = 48,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10,
  parameter int V_SW    = 2,
  parameter int V_BACK  = 33
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic ph_o,
  output logic pix_en_o,
  output logic hs_o,
  output logic vs_o,
  output logic vis_o,
  output logic frame_start_o,
  output logic vblank_start_o
);

  localparam logic [9:0] H_LAST =
    10'(H_ACT + H_FRONT + H_SW + H_BACK - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACT + V_FRONT + V_SW + V_BACK - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_ACT);
  localparam logic [9:0] V_VIS_L = 10'(V_ACT);
  localparam logic [9:0] HS_BEG  = 10'(H_ACT + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_ACT + H_FRONT + H_SW);
  localparam logic [9:0] VS_BEG  = 10'(V_ACT + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_ACT + V_FRONT + V_SW);

  logic       ph_q;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       h_end, v_end;

  assign h_end = (h_q == H_LAST);
  assign v_end = (v_q == V_LAST);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ph_q) begin
      h_d = h_end ? '0 : h_q + 10'd1;
      if (h_end)
        v_d = v_end ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q <= 1'b0;
      h_q  <= '0;
      v_q  <= '0;
    end else begin
      ph_q <= ~ph_q;
      h_q  <= h_d;
      v_q  <= v_d;
    end
  end

  assign ph_o           = ph_q;
  assign pix_en_o       = ph_q;
  assign hs_o           = ~((h_q >= HS_BEG) && (h_q < HS_END));
  assign vs_o           = ~((v_q >= VS_BEG) && (v_q < VS_END));
  assign vis_o          = (h_q < H_VIS_L) && (v_q < V_VIS_L);
  assign frame_start_o  = ph_q && h_end && v_end;
  assign vblank_start_o = ph_q && (h_q == '0) && (v_q == V_VIS_L);

endmodule

// File: rtl/sram_frame_scanout.sv
// Streams an RGB565 frame from async SRAM to the VGA DAC, with
// double-buffer swap at vertical blank and SRAM release in blanking.
module sram_frame_scanout
  import vga_scan_pkg::*;
#(
  parameter logic [19:0] FB0_BASE = 20'h00000,
  parameter logic [19:0] FB1_BASE = 20'h4B000,
  parameter int H_ACT   = H_VIS,
  parameter int H_FRONT = H_FP,
  parameter int H_SW    = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_VIS,
  parameter int V_FRONT = V_FP,
  parameter int V_SW    = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        frame_sel_req,
  input  logic        frame_sel,
  output logic        frame_sel_ack,
  output logic        sram_idle,
  input  logic [15:0] sram_DQ,
  output logic [19:0] sram_ADDR,
  output logic        sram_CE_N,
  output logic        sram_OE_N,
  output logic        sram_WE_N,
  output logic        sram_LB_N,
  output logic        sram_UB_N,
  output logic        vga_out_CLK,
  output logic        vga_out_HS,
  output logic        vga_out_VS,
  output logic        vga_out_BLANK,
  output logic        vga_out_SYNC,
  output logic [7:0]  vga_out_R,
  output logic [7:0]  vga_out_G,
  output logic [7:0]  vga_out_B
);

  logic ph, pix_en, hs_raw, vs_raw, vis;
  logic frame_start, vblank_start;

  vga_timing_gen #(
    .H_ACT  (H_ACT),
    .H_FRONT(H_FRONT),
    .H_SW   (H_SW),
    .H_BACK (H_BACK),
    .V_ACT  (V_ACT),
    .V_FRONT(V_FRONT),
    .V_SW   (V_SW),
    .V_BACK (V_BACK)
  ) u_tg (
    .clk_i         (clk_clk),
    .rst_i         (reset_reset),
    .ph_o          (ph),
    .pix_en_o      (pix_en),
    .hs_o          (hs_raw),
    .vs_o          (vs_raw),
    .vis_o         (vis),
    .frame_start_o (frame_start),
    .vblank_start_o(vblank_start)
  );

  logic [19:0] base_q, addr_q, sram_addr_q;
  logic        vis1_q, hs1_q, vs1_q;
  logic        hs_q, vs_q, blank_q;
  logic [23:0] rgb_q;
  logic        ack_q, held_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      base_q      <= FB0_BASE;
      addr_q      <= FB0_BASE;
      sram_addr_q <= '0;
      vis1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      rgb_q       <= '0;
      ack_q       <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      // a request stays consumed until req is released
      if (!frame_sel_req)
        held_q <= 1'b0;
      if (vblank_start && frame_sel_req && !held_q) begin
        base_q <= frame_sel ? FB1_BASE : FB0_BASE;
        ack_q  <= 1'b1;
        held_q <= 1'b1;
      end
      if (pix_en) begin
        vis1_q  <= vis;
        hs1_q   <= hs_raw;
        vs1_q   <= vs_raw;
        hs_q    <= hs1_q;
        vs_q    <= vs1_q;
        blank_q <= vis1_q;
        rgb_q   <= vis1_q ? rgb565_unpack(sram_DQ) : '0;
        if (frame_start) begin
          addr_q <= base_q;
        end else if (vis) begin
          sram_addr_q <= addr_q;
          addr_q      <= addr_q + 20'd1;
        end
      end
    end
  end

  assign sram_ADDR     = sram_addr_q;
  assign sram_CE_N     = ~vis1_q;
  assign sram_OE_N     = ~vis1_q;
  assign sram_LB_N     = ~vis1_q;
  assign sram_UB_N     = ~vis1_q;
  assign sram_WE_N     = 1'b1;
  assign sram_idle     = ~vis1_q;
  assign frame_sel_ack = ack_q;
  assign vga_out_CLK   = ph;
  assign vga_out_HS    = hs_q;
  assign vga_out_VS    = vs_q;
  assign vga_out_BLANK = blank_q;
  assign vga_out_SYNC  = 1'b0;
  assign {vga_out_R, vga_out_G, vga_out_B} = rgb_q;

endmodule

// File: tb/tb_sram_frame_scanout.sv
// Randomized check of sram_frame_scanout on a scaled raster against
// a slot-indexed reference model.
module tb_sram_frame_scanout;

  localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
  localparam int VA = 6,  VF = 2, VSW = 2, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam logic [19:0] FB0 = 20'h00000;
  localparam logic [19:0] FB1 = 20'h4B000;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst, req, sel;
  logic        ack, idle;
  logic [15:0] dq;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;
  logic        vclk, hs, vs, blank, sync;
  logic [7:0]  r, g, b;
  logic [15:0] key, mul;

  assign dq = (addr[15:0] * mul) ^ key;

  sram_frame_scanout #(
    .H_ACT(HA), .H_FRONT(HF), .H_SW(HSW), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_SW(VSW), .V_BACK(VB)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .frame_sel_req(req),
    .frame_sel    (sel),
    .frame_sel_ack(ack),
    .sram_idle    (idle),
    .sram_DQ      (dq),
    .sram_ADDR    (addr),
    .sram_CE_N    (ce_n),
    .sram_OE_N    (oe_n),
    .sram_WE_N    (we_n),
    .sram_LB_N    (lb_n),
    .sram_UB_N    (ub_n),
    .vga_out_CLK  (vclk),
    .vga_out_HS   (hs),
    .vga_out_VS   (vs),
    .vga_out_BLANK(blank),
    .vga_out_SYNC (sync),
    .vga_out_R    (r),
    .vga_out_G    (g),
    .vga_out_B    (b)
  );

  int nchk = 0, nfail = 0;
  int t;
  logic [19:0] act_b, frm_b, e_addr;
  logic        e_ack, held, e_ce_n, e_hs, e_vs, e_blank;
  logic [23:0] e_rgb;
  int dut_acks = 0, mdl_acks = 0;
  int rst_cnt, rphase = 0;
  int drv_idle = 0, drv_hold = 0;
  bit drv_acked = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic int hh(input int s); return s % HT; endfunction
  function automatic int vv(input int s); return (s / HT) % VT; endfunction

  function automatic logic vis_s(input int s);
    return hh(s) < HA && vv(s) < VA;
  endfunction

  function automatic logic hs_s(input int s);
    return !(hh(s) >= HA + HF && hh(s) < HA + HF + HSW);
  endfunction

  function automatic logic vs_s(input int s);
    return !(vv(s) >= VA + VF && vv(s) < VA + VF + VSW);
  endfunction

  function automatic logic [19:0] pix_addr(input logic [19:0] base,
                                           input int s);
    return base + 20'(vv(s) * HA + hh(s));
  endfunction

  function automatic logic [15:0] mem(input logic [19:0] a);
    return (a[15:0] * mul) ^ key;
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] d);
    int rr, gg, bb;
    rr = int'(d) / 2048;
    gg = (int'(d) / 32) % 64;
    bb = int'(d) % 32;
    rr = rr * 8 + rr / 4;
    gg = gg * 4 + gg / 16;
    bb = bb * 8 + bb / 4;
    return 24'(rr * 65536 + gg * 256 + bb);
  endfunction

  // model of one clock edge; t counts edges since reset release
  task automatic model_edge();
    int s, h, v;
    e_ack = 1'b0;
    if (rst) begin
      t = 0; act_b = FB0; frm_b = FB0; e_addr = '0; held = 1'b0;
      e_ce_n = 1'b1; e_hs = 1'b1; e_vs = 1'b1;
      e_blank = 1'b0; e_rgb = '0;
      return;
    end
    if (t % 2 == 1) begin
      s = t / 2; h = hh(s); v = vv(s);
      e_blank = s >= 1 && vis_s(s - 1);
      e_rgb   = e_blank ? expand(mem(pix_addr(frm_b, s - 1))) : '0;
      e_hs    = s >= 1 ? hs_s(s - 1) : 1'b1;
      e_vs    = s >= 1 ? vs_s(s - 1) : 1'b1;
      e_ce_n  = !vis_s(s);
      if (vis_s(s)) e_addr = pix_addr(frm_b, s);
      if (h == HT - 1 && v == VT - 1) frm_b = act_b;
      if (h == 0 && v == VA && req && !held) begin
        act_b = sel ? FB1 : FB0;
        e_ack = 1'b1;
        held  = 1'b1;
      end
    end
    if (!req) held = 1'b0;
    t++;
  endtask

  task automatic compare();
    chk("vga_clk", 32'(vclk), 32'(t % 2));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("ce_n", 32'(ce_n), 32'(e_ce_n));
    chk("oe_n", 32'(oe_n), 32'(e_ce_n));
    chk("lb_ub_n", 32'({lb_n, ub_n}), 32'({e_ce_n, e_ce_n}));
    chk("we_n", 32'(we_n), 32'd1);
    chk("idle", 32'(idle), 32'(e_ce_n));
    chk("hs", 32'(hs), 32'(e_hs));
    chk("vs", 32'(vs), 32'(e_vs));
    chk("blank", 32'(blank), 32'(e_blank));
    chk("sync", 32'(sync), 32'd0);
    chk("rgb", 32'({r, g, b}), 32'(e_rgb));
    chk("ack", 32'(ack), 32'(e_ack));
    dut_acks += int'(ack);
    mdl_acks += int'(e_ack);
  endtask

  task automatic start_reset();
    rst = 1'b1; rst_cnt = 3; req = 1'b0;
    drv_idle = $urandom_range(0, 400); drv_acked = 0;
  endtask

  task automatic stim();
    int s, h, v, f;
    if (rst_cnt > 0) begin
      rst_cnt--;
      if (rst_cnt == 0) rst = 1'b0;
      return;
    end
    s = t / 2; h = hh(s); v = vv(s); f = s / FT;
    if (t % 2 == 0 && h == 0 && v == VA + 1) begin
      if (f == 0) begin
        key = 16'hF803; mul = 16'd1;
      end else begin
        key = 16'($urandom); mul = 16'($urandom) | 16'd1;
      end
    end
    if (rphase == 0 && f == 3 && v == 3 && h == 7) begin
      rphase = 1; start_reset(); return;
    end
    if (rphase == 1 && f >= 2) begin
      if (v == VA - 2) req = 1'b0;
      if (v == VA - 1) begin req = 1'b1; sel = 1'b1; end
      if (h == 0 && v == VA && t % 2 == 1) begin
        rphase = 2; start_reset();
      end
      return;
    end
    if (s < FT) return;
    if (!req) begin
      if (drv_idle > 0) drv_idle--;
      else begin
        req = 1'b1; sel = 1'($urandom); drv_acked = 0;
      end
    end else if (!drv_acked) begin
      if (e_ack) begin
        drv_acked = 1; drv_hold = $urandom_range(0, 900);
      end
    end else if (drv_hold > 0) begin
      drv_hold--;
    end else begin
      req = 1'b0; drv_idle = $urandom_range(0, 900);
    end
  endtask

  initial begin
    rst = 1'b1; rst_cnt = 3; req = 1'b0; sel = 1'b0;
    key = 16'h0000; mul = 16'd1; t = 0;
    for (int c = 0; c < 14000; c++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
      stim();
    end
    chk("ack_count", 32'(dut_acks), 32'(mdl_acks));
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
